// File: rtl/clk_div_cfg_pkg.sv
// Shared types and helpers for the clock-divider reconfiguration arbiter.
package clk_div_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGate,
    StIssue,
    StSettle,
    StAck
  } state_e;

  // A single requester still gets a one-bit index so ports never collapse to zero width.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_cfg_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter
  import clk_div_cfg_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [N_REQ-1:0] w_rot;
  int unsigned      w_slot;
  logic             w_found;

  always_comb begin
    // Rotating a doubled copy puts the pointer's requester at bit 0.
    w_rot   = N_REQ'({i_req, i_req} >> i_ptr);
    w_slot  = 0;
    w_found = 1'b0;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      if (!w_found && w_rot[off]) begin
        w_found = 1'b1;
        w_slot  = int'(i_ptr) + off;
        if (w_slot >= N_REQ) begin
          w_slot = w_slot - N_REQ;
        end
        o_valid = 1'b1;
        o_idx   = IDX_W'(w_slot);
        o_gnt   = N_REQ'(1) << w_slot;
      end
    end
  end

endmodule

// File: rtl/clk_div_cfg_arbiter.sv
// Shares one clock divider between requesters: round-robin grant, enable gating
// around the div/valid/ready handshake, and a completion pulse back to the winner.
module clk_div_cfg_arbiter
  import clk_div_cfg_pkg::*;
#(
  parameter int unsigned N_REQ             = 2,
  parameter int unsigned DIV_VALUE_WIDTH   = 4,
  parameter int unsigned DEFAULT_DIV_VALUE = 2,
  parameter int unsigned GATE_CYCLES       = 2,
  parameter int unsigned SETTLE_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 64,
  parameter int unsigned IDX_W             = idx_width(N_REQ)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               en_req_i,
  input  logic [N_REQ-1:0]                   req_valid_i,
  input  logic [N_REQ*DIV_VALUE_WIDTH-1:0]   req_div_i,
  output logic [N_REQ-1:0]                   req_ready_o,
  input  logic                               err_clr_i,
  output logic [DIV_VALUE_WIDTH-1:0]         div_o,
  output logic                               div_valid_o,
  input  logic                               div_ready_i,
  output logic                               en_o,
  output logic [DIV_VALUE_WIDTH-1:0]         cur_div_o,
  output logic                               busy_o,
  output logic [IDX_W-1:0]                   grant_idx_o,
  output logic                               err_o
);

  localparam int unsigned CNT_MAX_A = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [DIV_VALUE_WIDTH-1:0] DEF_DIV = DIV_VALUE_WIDTH'(DEFAULT_DIV_VALUE);

  state_e                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [IDX_W-1:0]           r_ptr;
  logic [IDX_W-1:0]           r_idx;
  logic [N_REQ-1:0]           r_gnt;
  logic [N_REQ-1:0]           r_ready;
  logic [DIV_VALUE_WIDTH-1:0] r_div;
  logic [DIV_VALUE_WIDTH-1:0] r_cur;
  logic                       r_valid;
  logic                       r_en;
  logic                       r_busy;
  logic                       r_err;

  logic [N_REQ-1:0]           w_gnt;
  logic [IDX_W-1:0]           w_idx;
  logic                       w_any;
  logic [DIV_VALUE_WIDTH-1:0] w_req_div;
  logic [IDX_W-1:0]           w_ptr_next;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req   (req_valid_i),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  always_comb begin
    w_req_div  = req_div_i[int'(w_idx)*DIV_VALUE_WIDTH +: DIV_VALUE_WIDTH];
    w_ptr_next = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_gnt   <= '0;
      r_ready <= '0;
      r_div   <= DEF_DIV;
      r_cur   <= DEF_DIV;
      r_valid <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= '0;
      // Clear first so a timeout later in this block takes priority.
      if (err_clr_i) begin
        r_err <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          r_en <= en_req_i;
          if (w_any) begin
            r_gnt  <= w_gnt;
            r_idx  <= w_idx;
            r_div  <= w_req_div;
            r_busy <= 1'b1;
            r_cnt  <= '0;
            if (w_req_div == r_cur) begin
              r_state <= StAck;
              r_ready <= w_gnt;
            end else begin
              r_state <= StGate;
              r_en    <= 1'b0;
            end
          end
        end
        StGate: begin
          if (r_cnt == CNT_W'(GATE_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_state <= StIssue;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StIssue: begin
          if (div_ready_i) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_cur   <= r_div;
            r_state <= StSettle;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b1;
            r_state <= StSettle;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StSettle: begin
          if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_ready <= r_gnt;
            r_state <= StAck;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StAck: begin
          r_en    <= en_req_i;
          r_busy  <= 1'b0;
          r_ptr   <= w_ptr_next;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign div_o       = r_div;
  assign div_valid_o = r_valid;
  assign en_o        = r_en;
  assign cur_div_o   = r_cur;
  assign busy_o      = r_busy;
  assign grant_idx_o = r_idx;
  assign err_o       = r_err;

endmodule

// File: tb/tb_clk_div_cfg_arbiter.sv
// Directed bench for clk_div_cfg_arbiter; completions are checked against a
// queue of expected grant/value/error results pushed as each request is driven.
module tb_clk_div_cfg_arbiter;

  typedef struct packed {
    logic       idx;
    logic [3:0] cur;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en_req;
  logic [1:0] req_valid;
  logic [7:0] req_div;
  logic [1:0] req_ready;
  logic       err_clr;
  logic [3:0] div_o;
  logic       div_valid;
  logic       div_ready;
  logic       en_o;
  logic [3:0] cur_div;
  logic       busy;
  logic [0:0] grant_idx;
  logic       err;

  int   n_chk = 0;
  int   n_err = 0;
  int   n_ack = 0;
  int   cyc;
  int   n;
  exp_t sb[$];
  exp_t m_e;

  clk_div_cfg_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_req_i    (en_req),
    .req_valid_i (req_valid),
    .req_div_i   (req_div),
    .req_ready_o (req_ready),
    .err_clr_i   (err_clr),
    .div_o       (div_o),
    .div_valid_o (div_valid),
    .div_ready_i (div_ready),
    .en_o        (en_o),
    .cur_div_o   (cur_div),
    .busy_o      (busy),
    .grant_idx_o (grant_idx),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic idx, input logic [3:0] cur, input logic e);
    exp_t t;
    t.idx = idx;
    t.cur = cur;
    t.err = e;
    sb.push_back(t);
  endtask

  // Returns the number of edges until a completion pulse is visible.
  task automatic wait_ack(input string tag, output int edges);
    edges = 1;
    step(1);
    while (req_ready === 2'b00 && edges < 200) begin
      step(1);
      edges++;
    end
    check(tag, 32'(req_ready !== 2'b00), 1);
  endtask

  always @(negedge clk) begin
    if (!rst && req_ready !== 2'b00) begin
      n_ack++;
      if (sb.size() == 0) begin
        check("ack_unexpected", 32'(req_ready), 0);
      end else begin
        m_e = sb.pop_front();
        check("ack_onehot", 32'(req_ready), 32'(1) << m_e.idx);
        check("ack_grant", 32'(grant_idx), 32'(m_e.idx));
        check("ack_cur", 32'(cur_div), 32'(m_e.cur));
        check("ack_err", 32'(err), 32'(m_e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en_req = 1'b1; req_valid = '0; req_div = '0; err_clr = 1'b0; div_ready = 1'b0;
    step(2);
    check("rst_en", 32'(en_o), 0);
    check("rst_valid", 32'(div_valid), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_grant", 32'(grant_idx), 0);
    check("rst_div", 32'(div_o), 2);
    check("rst_cur", 32'(cur_div), 2);

    // Enable follows en_req with one cycle of latency in IDLE.
    rst = 1'b0;
    step(1);
    check("en_rise", 32'(en_o), 1);
    en_req = 1'b0;
    #1;
    check("en_delay", 32'(en_o), 1);
    step(1);
    check("en_fall", 32'(en_o), 0);
    en_req = 1'b1;
    step(1);
    check("en_rise2", 32'(en_o), 1);

    // Equal value: immediate ACK, no handshake, enable untouched.
    req_div[3:0] = 4'd2; req_valid = 2'b01;
    push_exp(1'b0, 4'd2, 1'b0);
    wait_ack("eq_ack", cyc);
    check("eq_lat", 32'(cyc), 1);
    check("eq_no_valid", 32'(div_valid), 0);
    check("eq_en", 32'(en_o), 1);
    req_valid = 2'b00;
    step(1);
    check("eq_idle_busy", 32'(busy), 0);
    check("eq_en_after", 32'(en_o), 1);

    // Timeout: ready never returned.
    req_div[3:0] = 4'd7; req_valid = 2'b01;
    push_exp(1'b0, 4'd2, 1'b1);
    step(3);
    check("to_valid_start", 32'(div_valid), 1);
    check("to_en_low", 32'(en_o), 0);
    n = 0;
    while (div_valid === 1'b1 && n < 200) begin
      n++;
      step(1);
    end
    check("to_valid_len", 32'(n), 64);
    check("to_err", 32'(err), 1);
    check("to_cur", 32'(cur_div), 2);
    wait_ack("to_ack", cyc);
    req_valid = 2'b00;
    step(1);
    check("to_err_sticky", 32'(err), 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("err_clr", 32'(err), 0);

    // Single request, ready on the third ISSUE cycle.
    req_div[3:0] = 4'd15; req_valid = 2'b01;
    push_exp(1'b0, 4'd15, 1'b0);
    step(1);
    check("s_gate_en", 32'(en_o), 0);
    check("s_div_o", 32'(div_o), 15);
    check("s_busy", 32'(busy), 1);
    check("s_gate1_valid", 32'(div_valid), 0);
    step(1);
    check("s_gate2_valid", 32'(div_valid), 0);
    step(1);
    check("s_issue_valid", 32'(div_valid), 1);
    step(2);
    div_ready = 1'b1;
    step(1);
    div_ready = 1'b0;
    check("s_done_valid", 32'(div_valid), 0);
    check("s_cur", 32'(cur_div), 15);
    check("s_settle_en0", 32'(en_o), 0);
    step(3);
    check("s_settle_en3", 32'(en_o), 0);
    check("s_no_early_ack", 32'(req_ready), 0);
    wait_ack("s_ack", cyc);
    check("s_ack_lat", 32'(cyc), 1);
    check("s_ack_en", 32'(en_o), 0);
    req_valid = 2'b00;
    step(1);
    check("s_en_back", 32'(en_o), 1);
    check("s_pulse_end", 32'(req_ready), 0);

    // Reset in the middle of ISSUE.
    req_div[7:4] = 4'd9; req_valid = 2'b10;
    step(4);
    check("r_in_issue", 32'(div_valid), 1);
    rst = 1'b1;
    step(1);
    check("r_valid", 32'(div_valid), 0);
    check("r_en", 32'(en_o), 0);
    check("r_busy", 32'(busy), 0);
    check("r_cur", 32'(cur_div), 2);
    check("r_div", 32'(div_o), 2);
    check("r_grant", 32'(grant_idx), 0);
    rst = 1'b0; req_valid = 2'b00;
    step(3);
    check("r_no_ack", 32'(n_ack), 3);

    // Round-robin with both requesters held; expected grants 0, 1, 0.
    div_ready = 1'b1;
    req_div = {4'd10, 4'd4}; req_valid = 2'b11;
    push_exp(1'b0, 4'd4, 1'b0);
    push_exp(1'b1, 4'd10, 1'b0);
    push_exp(1'b0, 4'd4, 1'b0);
    wait_ack("rr_ack0", cyc);
    check("rr_lat", 32'(cyc), 8);
    wait_ack("rr_ack1", cyc);
    req_valid[1] = 1'b0;
    wait_ack("rr_ack2", cyc);
    req_valid[0] = 1'b0;
    step(1);
    check("rr_final_cur", 32'(cur_div), 4);
    check("rr_final_grant", 32'(grant_idx), 0);

    // en_req low across a change keeps the divider disabled afterwards.
    en_req = 1'b0;
    req_div[3:0] = 4'd5; req_valid = 2'b01;
    push_exp(1'b0, 4'd5, 1'b0);
    wait_ack("enl_ack", cyc);
    check("enl_ack_en", 32'(en_o), 0);
    req_valid = 2'b00; div_ready = 1'b0;
    step(1);
    check("enl_after_ack", 32'(en_o), 0);
    step(2);
    check("enl_idle", 32'(en_o), 0);
    en_req = 1'b1;
    step(1);
    check("enl_restore", 32'(en_o), 1);

    check("sb_empty", 32'(sb.size()), 0);
    check("ack_total", 32'(n_ack), 7);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
